// File: rtl/hazard_scoreboard.sv
// Hazard controller: operand forwarding, load-use detection,
// long-latency scoreboard and stall/flush sequencing for F/D/E/M/W.
module hazard_scoreboard #(
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2,
  parameter int SEL_W   = $clog2(NUM_FWD + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      d_cache_stall,
  input  logic                      i_cache_stall,
  input  logic                      alu_stallE,
  input  logic                      flush_exceptionM,
  input  logic                      flush_pred_failedM,
  input  logic                      flush_jump_conflictE,
  input  logic [REG_AW-1:0]         rsD,
  input  logic [REG_AW-1:0]         rtD,
  input  logic [REG_AW-1:0]         writeregD,
  input  logic                      regwriteD,
  input  logic [REG_AW-1:0]         rsE,
  input  logic [REG_AW-1:0]         rtE,
  input  logic [REG_AW-1:0]         writeregE,
  input  logic                      regwriteE,
  input  logic                      mem_readE,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_addr,
  input  logic                      sb_issue,
  input  logic                      sb_done,
  input  logic [REG_AW-1:0]         sb_issue_reg,
  input  logic [REG_AW-1:0]         sb_done_reg,
  output logic                      stallF,
  output logic                      stallD,
  output logic                      stallE,
  output logic                      stallM,
  output logic                      stallW,
  output logic                      flushF,
  output logic                      flushD,
  output logic                      flushE,
  output logic                      flushM,
  output logic                      flushW,
  output logic [SEL_W-1:0]          forward_1E,
  output logic [SEL_W-1:0]          forward_2E,
  output logic                      sb_busy
);

  localparam int NREG = 1 << REG_AW;

  logic [NREG-1:0]  r_sb;
  logic [NREG-1:0]  w_sb_nxt;
  logic             r_busy;
  logic             r_dfr;
  logic             w_dfr_nxt;
  logic [SEL_W-1:0] w_fwd1;
  logic [SEL_W-1:0] w_fwd2;
  logic             w_lu;
  logic             w_sb_hit;
  logic             w_ms;
  logic             w_stallD;
  logic             w_stallE;
  logic             w_flushD;
  logic             w_flushE;
  logic             w_exc;

  // Forward select: scan oldest to youngest so the youngest match wins
  always_comb begin
    w_fwd1 = '0;
    w_fwd2 = '0;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_valid[k]) begin
        if (rsE != '0 &&
            fwd_addr[k*REG_AW +: REG_AW] == rsE)
          w_fwd1 = SEL_W'(k + 1);
        if (rtE != '0 &&
            fwd_addr[k*REG_AW +: REG_AW] == rtE)
          w_fwd2 = SEL_W'(k + 1);
      end
    end
  end

  // Scoreboard next state: clear first so a same-register set wins
  always_comb begin
    w_sb_nxt = r_sb;
    if (sb_done)
      w_sb_nxt[sb_done_reg] = 1'b0;
    if (sb_issue && sb_issue_reg != '0)
      w_sb_nxt[sb_issue_reg] = 1'b1;
  end

  // Deferred jump-conflict flush held across a data-cache stall
  always_comb begin
    w_dfr_nxt = r_dfr;
    if (flush_exceptionM || !d_cache_stall)
      w_dfr_nxt = 1'b0;
    else if (flush_jump_conflictE)
      w_dfr_nxt = 1'b1;
  end

  // Scoreboard, busy flag and deferred flush state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb   <= '0;
      r_busy <= 1'b0;
      r_dfr  <= 1'b0;
    end else begin
      r_sb   <= w_sb_nxt;
      r_busy <= |w_sb_nxt;
      r_dfr  <= w_dfr_nxt;
    end
  end

  // Hazard detection and stall/flush equations
  always_comb begin
    w_exc = flush_exceptionM;
    w_ms  = d_cache_stall | alu_stallE;
    w_lu  = regwriteE & mem_readE &
            (writeregE != '0) &
            ((writeregE == rsD) |
             (writeregE == rtD));
    w_sb_hit = r_sb[rsD] | r_sb[rtD] |
               (regwriteD & r_sb[writeregD]);
    w_stallD = w_ms | i_cache_stall |
               w_lu | w_sb_hit;
    w_stallE = w_ms;
    w_flushD = w_exc | flush_pred_failedM |
               (flush_jump_conflictE & ~d_cache_stall) |
               (r_dfr & ~d_cache_stall);
    w_flushE = w_exc |
               (flush_pred_failedM & ~alu_stallE) |
               (w_stallD & ~w_stallE);
  end

  // Outputs forced quiet while reset is held
  always_comb begin
    stallD     = w_stallD & ~rst;
    stallF     = w_stallD & ~w_exc & ~rst;
    stallE     = w_stallE & ~rst;
    stallM     = w_stallE & ~rst;
    stallW     = w_stallE & ~rst;
    flushF     = 1'b0;
    flushD     = w_flushD & ~rst;
    flushE     = w_flushE & ~rst;
    flushM     = w_exc & ~rst;
    flushW     = 1'b0;
    forward_1E = rst ? '0 : w_fwd1;
    forward_2E = rst ? '0 : w_fwd2;
    sb_busy    = r_busy & ~rst;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with
// immediate-assertion checks.
module tb_hazard_scoreboard;

  localparam int REG_AW  = 5;
  localparam int NUM_FWD = 2;
  localparam int SEL_W   = $clog2(NUM_FWD + 1);

  logic clk = 1'b0;
  logic rst;
  logic d_cache_stall, i_cache_stall, alu_stallE;
  logic flush_exceptionM, flush_pred_failedM;
  logic flush_jump_conflictE;
  logic [REG_AW-1:0] rsD, rtD, writeregD;
  logic regwriteD;
  logic [REG_AW-1:0] rsE, rtE, writeregE;
  logic regwriteE, mem_readE;
  logic [NUM_FWD-1:0] fwd_valid;
  logic [NUM_FWD*REG_AW-1:0] fwd_addr;
  logic sb_issue, sb_done;
  logic [REG_AW-1:0] sb_issue_reg, sb_done_reg;
  logic stallF, stallD, stallE, stallM, stallW;
  logic flushF, flushD, flushE, flushM, flushW;
  logic [SEL_W-1:0] forward_1E, forward_2E;
  logic sb_busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)
  ) dut (
    .clk(clk), .rst(rst),
    .d_cache_stall(d_cache_stall),
    .i_cache_stall(i_cache_stall),
    .alu_stallE(alu_stallE),
    .flush_exceptionM(flush_exceptionM),
    .flush_pred_failedM(flush_pred_failedM),
    .flush_jump_conflictE(flush_jump_conflictE),
    .rsD(rsD), .rtD(rtD), .writeregD(writeregD),
    .regwriteD(regwriteD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
    .regwriteE(regwriteE), .mem_readE(mem_readE),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .sb_issue(sb_issue), .sb_done(sb_done),
    .sb_issue_reg(sb_issue_reg),
    .sb_done_reg(sb_done_reg),
    .stallF(stallF), .stallD(stallD),
    .stallE(stallE), .stallM(stallM),
    .stallW(stallW),
    .flushF(flushF), .flushD(flushD),
    .flushE(flushE), .flushM(flushM),
    .flushW(flushW),
    .forward_1E(forward_1E),
    .forward_2E(forward_2E),
    .sb_busy(sb_busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_cache_stall = 0; i_cache_stall = 0;
    alu_stallE = 0; flush_exceptionM = 0;
    flush_pred_failedM = 0;
    flush_jump_conflictE = 0;
    rsD = 0; rtD = 0; writeregD = 0;
    regwriteD = 0;
    rsE = 0; rtE = 0; writeregE = 0;
    regwriteE = 0; mem_readE = 0;
    fwd_valid = 0; fwd_addr = 0;
    sb_issue = 0; sb_done = 0;
    sb_issue_reg = 0; sb_done_reg = 0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    d_cache_stall = 1; flush_exceptionM = 1;
    #2;
    chk("rst_stallD", stallD, 0);
    chk("rst_stallE", stallE, 0);
    chk("rst_flushD", flushD, 0);
    chk("rst_flushM", flushM, 0);
    chk("rst_busy", sb_busy, 0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    chk("idle_stallD", stallD, 0);
    chk("idle_flushE", flushE, 0);

    // forwarding
    fwd_valid = 2'b11;
    fwd_addr = {5'd5, 5'd5};
    rsE = 5; #1;
    chk("fwd_both", forward_1E, 1);
    fwd_addr = {5'd5, 5'd7}; #1;
    chk("fwd_older", forward_1E, 2);
    fwd_valid = 2'b10;
    fwd_addr = {5'd5, 5'd5}; #1;
    chk("fwd_valid_mask", forward_1E, 2);
    fwd_valid = 2'b00; #1;
    chk("fwd_none", forward_1E, 0);
    fwd_valid = 2'b11;
    fwd_addr = 0; rsE = 0; rtE = 0; #1;
    chk("fwd_r0_rs", forward_1E, 0);
    chk("fwd_r0_rt", forward_2E, 0);
    fwd_addr = {5'd9, 5'd4}; rtE = 9; #1;
    chk("fwd_rt", forward_2E, 2);
    idle();
    tick();

    // load-use
    mem_readE = 1; regwriteE = 1;
    writeregE = 8; rtD = 8; #1;
    chk("lu_stallF", stallF, 1);
    chk("lu_stallD", stallD, 1);
    chk("lu_flushE", flushE, 1);
    chk("lu_stallE", stallE, 0);
    tick();
    idle(); #1;
    chk("lu_clr_stallD", stallD, 0);
    chk("lu_clr_flushE", flushE, 0);
    regwriteE = 1; mem_readE = 1;
    writeregE = 0; rsD = 0; #1;
    chk("lu_r0", stallD, 0);
    idle();
    // load-use with memory stall: bubble masked
    d_cache_stall = 1; mem_readE = 1;
    regwriteE = 1; writeregE = 8; rsD = 8; #1;
    chk("lu_ms_stallE", stallE, 1);
    chk("lu_ms_flushE", flushE, 0);
    idle();
    tick();

    // scoreboard issue / done
    sb_issue = 1; sb_issue_reg = 12; rsD = 12; #1;
    chk("sb_pre_hit", stallD, 0);
    tick();
    sb_issue = 0; #1;
    chk("sb_hit", stallD, 1);
    chk("sb_busy_set", sb_busy, 1);
    sb_done = 1; sb_done_reg = 12; #1;
    chk("sb_done_cycle", stallD, 1);
    tick();
    sb_done = 0; #1;
    chk("sb_cleared", stallD, 0);
    chk("sb_busy_clr", sb_busy, 0);
    rsD = 0;

    // same-edge issue and done on reg 3
    sb_issue = 1; sb_issue_reg = 3;
    sb_done = 1; sb_done_reg = 3;
    tick();
    sb_issue = 0; sb_done = 0;
    regwriteD = 1; writeregD = 3; #1;
    chk("sb_same_waw", stallD, 1);
    chk("sb_same_busy", sb_busy, 1);
    regwriteD = 0; #1;
    chk("sb_waw_gated", stallD, 0);
    // issue 5 and done 3 together
    sb_issue = 1; sb_issue_reg = 5;
    sb_done = 1; sb_done_reg = 3;
    tick();
    sb_issue = 0; sb_done = 0;
    rtD = 3; #1;
    chk("sb_diff_done", stallD, 0);
    rtD = 5; #1;
    chk("sb_diff_issue", stallD, 1);
    sb_done = 1; sb_done_reg = 5;
    tick();
    idle(); #1;
    chk("sb_empty", sb_busy, 0);

    // deferred flush
    flush_jump_conflictE = 1; d_cache_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("dfr_hold_flushD", flushD, 0);
      tick();
    end
    idle(); #1;
    chk("dfr_release", flushD, 1);
    tick();
    chk("dfr_once", flushD, 0);

    // exception priority
    flush_jump_conflictE = 1; d_cache_stall = 1;
    tick();
    flush_jump_conflictE = 0;
    flush_exceptionM = 1;
    mem_readE = 1; regwriteE = 1;
    writeregE = 8; rsD = 8; #1;
    chk("exc_stallF", stallF, 0);
    chk("exc_flushD", flushD, 1);
    chk("exc_flushE", flushE, 1);
    chk("exc_flushM", flushM, 1);
    tick();
    idle(); #1;
    chk("exc_dfr_clr", flushD, 0);

    // reset mid-operation
    for (int r = 1; r <= 4; r++) begin
      sb_issue = 1;
      sb_issue_reg = 5'(r * 2 - 1);
      tick();
    end
    sb_issue = 0;
    flush_jump_conflictE = 1; d_cache_stall = 1;
    tick();
    flush_jump_conflictE = 0;
    rsD = 1; rtD = 3; #1;
    chk("mid_busy", sb_busy, 1);
    chk("mid_stallD", stallD, 1);
    #1 rst = 1'b1; #1;
    chk("mid_rst_stallD", stallD, 0);
    chk("mid_rst_stallE", stallE, 0);
    chk("mid_rst_busy", sb_busy, 0);
    tick();
    rst = 1'b0;
    d_cache_stall = 0; #1;
    chk("post_rst_stallD", stallD, 0);
    chk("post_rst_flushD", flushD, 0);
    chk("post_rst_busy", sb_busy, 0);
    tick();
    chk("post_rst_stallD2", stallD, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
